// File: rtl/icache_dm_pkg.sv
// ----------------------------------------------------------------------------
// icache_dm_pkg
// Shared types for the direct-mapped instruction cache.
//   addr_t / instr_t   default-width address and instruction types
//   icache_state_t     refill controller states (IDLE, FILL)
//   safe_w()           clamps a derived field width to at least one bit so
//                      zero-width fields (e.g. one word per line) still give
//                      legal vector declarations
// ----------------------------------------------------------------------------
package icache_dm_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] instr_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    function automatic int safe_w(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/icache_dm_array.sv
// ----------------------------------------------------------------------------
// icache_dm_array
// Tag, valid and data storage for the direct-mapped instruction cache.
// Ports:
//   clk, nrst                     clock, async active-low reset (valid bits only)
//   rd_idx, rd_off                asynchronous read address (set, word in line)
//   rd_valid, rd_tag, rd_data     read results
//   data_we, wr_idx, wr_off,      data word write port
//   wr_data
//   tag_we, wr_valid, wr_tag      tag + valid write for line wr_idx
//   inval_en, inval_idx           clear one valid bit
//   clear_all                     clear every valid bit (wins over other writes)
// Data and tag arrays are not reset: a line is only ever read through its
// valid bit, which is.
// ----------------------------------------------------------------------------
module icache_dm_array
    import icache_dm_pkg::*;
#(
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_W         = 32,
    parameter int TAG_W          = 24,
    parameter int IDX_W          = 4,
    parameter int OFF_SW         = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_SW-1:0] rd_off,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              data_we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_SW-1:0] wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic              wr_valid,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              inval_en,
    input  logic [IDX_W-1:0]  inval_idx,
    input  logic              clear_all
);

    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [TAG_W-1:0]  tag_d  [SETS];
    logic [DATA_W-1:0] data_q [SETS][WORDS_PER_LINE];
    logic [DATA_W-1:0] data_d [SETS][WORDS_PER_LINE];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx][rd_off];

    always_comb begin
        valid_d = valid_q;
        if (inval_en) valid_d[inval_idx] = 1'b0;
        if (tag_we)   valid_d[wr_idx]    = wr_valid;
        // A flush must never be undone by a line completing in the same cycle.
        if (clear_all) valid_d = '0;
    end

    always_comb begin
        tag_d = tag_q;
        if (tag_we) tag_d[wr_idx] = wr_tag;
    end

    always_comb begin
        data_d = data_q;
        if (data_we) data_d[wr_idx][wr_off] = wr_data;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/icache_dm.sv
// ----------------------------------------------------------------------------
// icache_dm
// Direct-mapped, read-only instruction cache with burst line refill.
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   cpu_req, cpu_addr    fetch request and byte address (bits [1:0] ignored)
//   cpu_rdata, cpu_ready instruction and same-cycle hit indication
//   flush                one-cycle pulse invalidating the whole cache
//   mem_req, mem_addr    refill word request (level) and word-aligned address
//   mem_ack, mem_rdata   one-cycle completion pulse and refill data
//   dbg_state            current controller state
// Handshake: in FILL, mem_req stays high with a stable mem_addr until a cycle
// with mem_ack=1; that cycle transfers mem_rdata for the current word. The
// fetch side sees a transfer in any cycle where cpu_req=1 and cpu_ready=1.
// ----------------------------------------------------------------------------
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output icache_state_t     dbg_state
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
    localparam int OFF_SW = safe_w(OFF_W);

    // ------------------------------------------------------------------
    // Address split
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  cpu_idx;
    logic [OFF_SW-1:0] cpu_off;

    assign cpu_tag = TAG_W'(cpu_addr >> (IDX_W + OFF_W + 2));
    assign cpu_idx = IDX_W'(cpu_addr >> (OFF_W + 2));
    // With one word per line there is no offset field at all.
    assign cpu_off = (OFF_W == 0) ? '0 : OFF_SW'(cpu_addr >> 2);

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    icache_state_t     state_q, state_d;
    logic [OFF_SW-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0]  line_tag_q, line_tag_d;
    logic [IDX_W-1:0]  line_idx_q, line_idx_d;
    logic              flush_pending_q, flush_pending_d;

    // Array interface
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              data_we;
    logic              tag_we;
    logic              wr_valid;
    logic              inval_en;
    logic              clear_all;

    logic in_idle, in_fill, hit, miss, cnt_last, last_ack;

    assign in_idle  = (state_q == IDLE);
    assign in_fill  = (state_q == FILL);
    assign cnt_last = (cnt_q == OFF_SW'(WORDS_PER_LINE - 1));
    assign last_ack = in_fill & mem_ack & cnt_last;

    // A flush in this very cycle suppresses the hit so no stale word escapes.
    assign hit  = in_idle & cpu_req & rd_valid & (rd_tag == cpu_tag)
                  & ~flush_pending_q & ~flush;
    assign miss = in_idle & cpu_req & ~hit;

    assign cpu_ready = hit;
    assign cpu_rdata = hit ? rd_data : '0;

    assign mem_req  = in_fill;
    assign mem_addr = in_fill
                      ? ((ADDR_W'(line_tag_q) << (IDX_W + OFF_W + 2))
                         | (ADDR_W'(line_idx_q) << (OFF_W + 2))
                         | (ADDR_W'(cnt_q) << 2))
                      : '0;

    assign dbg_state = state_q;

    // Array write controls
    assign data_we   = in_fill & mem_ack;
    assign tag_we    = last_ack;
    // A flush seen at any point of the refill, including the final ack
    // cycle, leaves the freshly filled line invalid.
    assign wr_valid  = ~(flush_pending_q | flush);
    assign inval_en  = miss;
    assign clear_all = (in_idle & flush) | (last_ack & (flush_pending_q | flush));

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        line_tag_d      = line_tag_q;
        line_idx_d      = line_idx_q;
        flush_pending_d = flush_pending_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d    = FILL;
                    line_tag_d = cpu_tag;
                    line_idx_d = cpu_idx;
                    cnt_d      = '0;
                end
            end
            FILL: begin
                if (flush) flush_pending_d = 1'b1;
                if (mem_ack) begin
                    if (cnt_last) begin
                        cnt_d           = '0;
                        state_d         = IDLE;
                        flush_pending_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            line_tag_q      <= '0;
            line_idx_q      <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            line_tag_q      <= line_tag_d;
            line_idx_q      <= line_idx_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    icache_dm_array #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .DATA_W         (DATA_W),
        .TAG_W          (TAG_W),
        .IDX_W          (IDX_W),
        .OFF_SW         (OFF_SW)
    ) u_array (
        .clk       (clk),
        .nrst      (nrst),
        .rd_idx    (cpu_idx),
        .rd_off    (cpu_off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .data_we   (data_we),
        .wr_idx    (line_idx_q),
        .wr_off    (cnt_q),
        .wr_data   (mem_rdata),
        .tag_we    (tag_we),
        .wr_valid  (wr_valid),
        .wr_tag    (line_tag_q),
        .inval_en  (inval_en),
        .inval_idx (cpu_idx),
        .clear_all (clear_all)
    );

endmodule

// File: tb/tb_icache_dm.sv
// ----------------------------------------------------------------------------
// tb_icache_dm
// Drives icache_dm (32-bit address/data, 16 sets, 4 words per line) and
// compares it with a line-level model: a set of (valid, tag) entries and a
// memory image; data is always what the memory image holds at that address.
// ----------------------------------------------------------------------------
module tb_icache_dm;
    import icache_dm_pkg::*;

    localparam int SETS = 16;
    localparam int WPL  = 4;
    localparam int LINE_BYTES = WPL * 4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    icache_state_t dbg_state;

    always #5 clk = ~clk;

    icache_dm #(
        .ADDR_W (32), .DATA_W (32), .SETS (SETS), .WORDS_PER_LINE (WPL)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Reference model + scoreboard
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];              // expected refill word addresses
    logic [31:0] mem_img [int unsigned];
    bit          m_valid [SETS];
    int unsigned m_tag   [SETS];

    function automatic int unsigned m_idx_of(input logic [31:0] a);
        return (a / LINE_BYTES) % SETS;
    endfunction

    function automatic int unsigned m_tag_of(input logic [31:0] a);
        return a / (LINE_BYTES * SETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[m_idx_of(a)] && (m_tag[m_idx_of(a)] == m_tag_of(a));
    endfunction

    function automatic void model_clear_all();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int unsigned key;
        key = a & ~32'h3;
        if (!mem_img.exists(key)) mem_img[key] = $urandom;
        return mem_img[key];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic apply_reset();
        @(negedge clk);
        nrst = 1'b0; cpu_req = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_mem_req",   mem_req,   0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        model_clear_all();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // One fetch of addr. If the model predicts a miss the line is refilled
    // with ack gaps of dmin..dmax cycles. flush_word >= 0 pulses flush on that
    // word's ack cycle; rst_word >= 0 pulls reset at the start of that word;
    // flush_now pulses flush on the request cycle itself.
    task automatic fetch(input logic [31:0] addr, input int dmin, input int dmax,
                         input int flush_word, input int rst_word, input bit flush_now);
        bit          exp_hit;
        bit          flushed;
        int          d;
        logic [31:0] base;
        logic [31:0] exp_a;

        if (flush_now) model_clear_all();
        exp_hit = model_hit(addr);

        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = addr; flush = flush_now; mem_ack = 1'b0;
        #1;
        check("req_ready", cpu_ready, exp_hit);
        check("req_mem_req", mem_req, 0);
        if (exp_hit) begin
            check("hit_data", cpu_rdata, mem_word(addr));
        end else begin
            base = addr & ~(LINE_BYTES - 1);
            flushed = 1'b0;
            for (int w = 0; w < WPL; w++) exp_q.push_back(base + 4 * w);
            for (int w = 0; w < WPL; w++) begin
                d = $urandom_range(dmin, dmax);
                exp_a = exp_q.pop_front();
                for (int k = 0; k <= d; k++) begin
                    @(negedge clk);
                    if (w == rst_word && k == 0) begin
                        nrst = 1'b0; mem_ack = 1'b0; flush = 1'b0; cpu_req = 1'b0;
                        #1;
                        check("midrst_mem_req",   mem_req,   0);
                        check("midrst_mem_addr",  mem_addr,  0);
                        check("midrst_cpu_ready", cpu_ready, 0);
                        check("midrst_cpu_rdata", cpu_rdata, 0);
                        model_clear_all();
                        exp_q.delete();
                        @(negedge clk);
                        nrst = 1'b1;
                        return;
                    end
                    // Fetch side wanders during the refill; it must be ignored.
                    cpu_req   = 1'($urandom_range(0, 1));
                    cpu_addr  = $urandom;
                    mem_ack   = (k == d);
                    mem_rdata = (k == d) ? mem_word(exp_a) : $urandom;
                    flush     = (k == d) && (w == flush_word);
                    if (flush) flushed = 1'b1;
                    #1;
                    check("fill_mem_req",   mem_req,   1);
                    check("fill_mem_addr",  mem_addr,  exp_a);
                    check("fill_cpu_ready", cpu_ready, 0);
                end
            end
            @(negedge clk);
            mem_ack = 1'b0; flush = 1'b0;
            if (flushed) begin
                model_clear_all();
                cpu_req = 1'b0;
                #1;
                check("post_fill_mem_req", mem_req, 0);
                check("post_fill_ready", cpu_ready, 0);
            end else begin
                m_valid[m_idx_of(addr)] = 1'b1;
                m_tag[m_idx_of(addr)]   = m_tag_of(addr);
                cpu_req = 1'b1; cpu_addr = addr;
                #1;
                check("post_fill_mem_req", mem_req, 0);
                check("post_fill_ready", cpu_ready, 1);
                check("post_fill_data", cpu_rdata, mem_word(addr));
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] a;
        int r;

        for (int i = 0; i < 4; i++) mem_img[32'h40 + 4 * i] = 32'hA0 + i;

        apply_reset();

        // Cold miss on 0x40, then hit within the same line.
        fetch(32'h40, 0, 0, -1, -1, 1'b0);
        fetch(32'h48, 0, 0, -1, -1, 1'b0);
        check("dir_0x48_data", cpu_rdata, 32'hA2);

        // Conflict: 0x440 evicts 0x40, which then misses again.
        fetch(32'h440, 0, 1, -1, -1, 1'b0);
        fetch(32'h40,  0, 1, -1, -1, 1'b0);

        // Slow memory: five idle cycles before every ack.
        fetch(32'h0C0, 5, 5, -1, -1, 1'b0);

        // Flush in the middle of a refill of 0x80.
        fetch(32'h80, 0, 2, 1, -1, 1'b0);
        fetch(32'h40, 0, 0, -1, -1, 1'b0);
        fetch(32'h80, 0, 0, -1, -1, 1'b0);

        // Flush on the final ack cycle.
        fetch(32'h100, 0, 1, WPL - 1, -1, 1'b0);
        fetch(32'h100, 0, 0, -1, -1, 1'b0);

        // Flush in IDLE coincident with a request to a resident line.
        fetch(32'h104, 0, 0, -1, -1, 1'b0);
        fetch(32'h104, 0, 0, -1, -1, 1'b1);

        // Reset while word 2 of a refill is outstanding.
        fetch(32'h200, 0, 0, -1, 2, 1'b0);
        fetch(32'h40,  0, 0, -1, -1, 1'b0);

        // Randomised traffic over 4 tags x 16 sets.
        for (int n = 0; n < 250; n++) begin
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4)
                | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            r = $urandom_range(0, 15);
            if (r == 0)      fetch(a, 0, 2, -1, -1, 1'b1);
            else if (r == 1) fetch(a, 0, 2, $urandom_range(0, WPL - 1), -1, 1'b0);
            else if (r == 2 && n % 50 == 7) fetch(a, 0, 2, -1, $urandom_range(0, WPL - 1), 1'b0);
            else             fetch(a, 0, 2, -1, -1, 1'b0);
        end

        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check("idle_no_req_ready", cpu_ready, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
